// File: rtl/mux_ctrl_pkg.sv
// Shared definitions for the datapath mux controllers: FSM state encoding,
// mux select constants and small index/one-hot helpers.
package mux_ctrl_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } state_t;

  localparam logic [1:0] SEL_0    = 2'b00;
  localparam logic [1:0] SEL_1    = 2'b01;
  localparam logic [1:0] SEL_2    = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b11;

  // One-hot grant vector for a requester index (0..2); index 3 gives no grant.
  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    logic [2:0] v;
    v = '0;
    case (idx)
      2'd0:    v = 3'b001;
      2'd1:    v = 3'b010;
      2'd2:    v = 3'b100;
      default: v = '0;
    endcase
    return v;
  endfunction

  // Mux select constant for a requester index.
  function automatic logic [1:0] sel_of(input logic [1:0] idx);
    logic [1:0] s;
    case (idx)
      2'd0:    s = SEL_0;
      2'd1:    s = SEL_1;
      2'd2:    s = SEL_2;
      default: s = SEL_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational 3-way round-robin picker. Search order starts just after
// last_grant and ends on last_grant itself, so the previous owner is lowest.
module rr_pick3 (
  input  logic [2:0] req,
  input  logic [1:0] last_grant,
  output logic       valid,
  output logic [1:0] winner
);

  // Pick the first requesting index in rotated priority order.
  always_comb begin
    valid  = |req;
    winner = '0;
    case (last_grant)
      2'd0: begin
        if      (req[1]) winner = 2'd1;
        else if (req[2]) winner = 2'd2;
        else             winner = 2'd0;
      end
      2'd1: begin
        if      (req[2]) winner = 2'd2;
        else if (req[0]) winner = 2'd0;
        else             winner = 2'd1;
      end
      default: begin
        if      (req[0]) winner = 2'd0;
        else if (req[1]) winner = 2'd1;
        else             winner = 2'd2;
      end
    endcase
  end

endmodule

// File: rtl/mux_port_arbiter.sv
// Round-robin arbiter owning the select of a shared 32-bit 3:1 mux. A grant
// lasts one transaction (until done), ends early if the owner drops its
// request, and is force-released by a hold watchdog after MAX_HOLD cycles.
module mux_port_arbiter
  import mux_ctrl_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic [2:0] req,
  input  logic       done,
  output logic [2:0] grant,
  output logic [1:0] controlSelect,
  output logic       busy,
  output logic       timeoutErr
);

  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_n;
  logic [1:0]       last_grant, last_grant_n;
  logic [2:0]       grant_n;
  logic [1:0]       sel_n;
  logic             busy_n;
  logic             timeout_n;
  logic             pick_valid;
  logic [1:0]       pick_winner;

  // While GRANTED, last_grant always equals the current owner, so one picker
  // serves both the IDLE pick and the back-to-back pick on done.
  rr_pick3 u_pick (
    .req        (req),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  // Next-state and registered-output computation.
  always_comb begin
    state_n      = state;
    hold_cnt_n   = hold_cnt;
    last_grant_n = last_grant;
    grant_n      = grant;
    sel_n        = controlSelect;
    busy_n       = busy;
    timeout_n    = 1'b0;

    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_n      = GRANTED;
          grant_n      = onehot3(pick_winner);
          sel_n        = sel_of(pick_winner);
          busy_n       = 1'b1;
          last_grant_n = pick_winner;
          hold_cnt_n   = '0;
        end
      end
      GRANTED: begin
        if (done) begin
          if (pick_valid) begin
            grant_n      = onehot3(pick_winner);
            sel_n        = sel_of(pick_winner);
            last_grant_n = pick_winner;
            hold_cnt_n   = '0;
          end else begin
            state_n = IDLE;
            grant_n = '0;
            sel_n   = SEL_NONE;
            busy_n  = 1'b0;
          end
        end else if ((req & grant) == 3'b000) begin
          state_n = IDLE;
          grant_n = '0;
          sel_n   = SEL_NONE;
          busy_n  = 1'b0;
        end else if (hold_cnt == HOLD_LIMIT) begin
          state_n   = IDLE;
          grant_n   = '0;
          sel_n     = SEL_NONE;
          busy_n    = 1'b0;
          timeout_n = 1'b1;
        end else begin
          hold_cnt_n = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
        sel_n   = SEL_NONE;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State, counter and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state         <= IDLE;
      hold_cnt      <= '0;
      last_grant    <= 2'd2;
      grant         <= '0;
      controlSelect <= SEL_NONE;
      busy          <= 1'b0;
      timeoutErr    <= 1'b0;
    end else begin
      state         <= state_n;
      hold_cnt      <= hold_cnt_n;
      last_grant    <= last_grant_n;
      grant         <= grant_n;
      controlSelect <= sel_n;
      busy          <= busy_n;
      timeoutErr    <= timeout_n;
    end
  end

endmodule

// File: tb/tb_mux_port_arbiter.sv
// Scoreboard bench for mux_port_arbiter: each stimulus step queues the outputs
// expected after the next rising edge; a negedge monitor pops and compares.
module tb_mux_port_arbiter;

  logic       clk = 1'b0;
  logic       rstN;
  logic [2:0] req;
  logic       done;
  logic [2:0] grant;
  logic [1:0] controlSelect;
  logic       busy;
  logic       timeoutErr;

  typedef struct {
    int         cyc;
    logic [2:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       to;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   cyc_no = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  mux_port_arbiter #(.MAX_HOLD(16), .CNT_W(5)) dut (
    .clk           (clk),
    .rstN          (rstN),
    .req           (req),
    .done          (done),
    .grant         (grant),
    .controlSelect (controlSelect),
    .busy          (busy),
    .timeoutErr    (timeoutErr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_no <= cyc_no + 1;

  // Monitor: compare every expectation tagged for the current cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_no) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      if (e.cyc != cyc_no || grant !== e.grant || controlSelect !== e.sel ||
          busy !== e.busy || timeoutErr !== e.to) begin
        n_bad++;
        $display("FAIL %s cyc=%0d: got grant=%b sel=%b busy=%b to=%b, required grant=%b sel=%b busy=%b to=%b (for cyc %0d)",
                 e.name, cyc_no, grant, controlSelect, busy, timeoutErr,
                 e.grant, e.sel, e.busy, e.to, e.cyc);
      end
    end
  end

  // Drive inputs for the next edge and queue the outputs required after it.
  task automatic step(input logic r, input logic [2:0] rq, input logic d,
                      input logic [2:0] eg, input logic [1:0] es,
                      input logic eb, input logic et, input string nm);
    exp_t e;
    rstN = r;
    req  = rq;
    done = d;
    e.cyc = cyc_no + 1; e.grant = eg; e.sel = es; e.busy = eb; e.to = et; e.name = nm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstN = 1'b0; req = 3'b111; done = 1'b0;
    #1;
    // T1 reset with all requests asserted
    step(0, 3'b111, 0, 3'b000, 2'b11, 0, 0, "t1_reset_a");
    step(0, 3'b111, 0, 3'b000, 2'b11, 0, 0, "t1_reset_b");

    // T2 fairness: done every third cycle, no idle bubble
    step(1, 3'b111, 0, 3'b001, 2'b00, 1, 0, "t2_g0");
    step(1, 3'b111, 0, 3'b001, 2'b00, 1, 0, "t2_g0_hold");
    step(1, 3'b111, 1, 3'b010, 2'b01, 1, 0, "t2_g1");
    step(1, 3'b111, 0, 3'b010, 2'b01, 1, 0, "t2_g1_hold_a");
    step(1, 3'b111, 0, 3'b010, 2'b01, 1, 0, "t2_g1_hold_b");
    step(1, 3'b111, 1, 3'b100, 2'b10, 1, 0, "t2_g2");
    step(1, 3'b111, 0, 3'b100, 2'b10, 1, 0, "t2_g2_hold_a");
    step(1, 3'b111, 0, 3'b100, 2'b10, 1, 0, "t2_g2_hold_b");
    step(1, 3'b111, 1, 3'b001, 2'b00, 1, 0, "t2_g0_again");
    step(1, 3'b000, 1, 3'b000, 2'b11, 0, 0, "t2_idle");

    // T3 single requester re-granted back-to-back
    step(1, 3'b010, 0, 3'b010, 2'b01, 1, 0, "t3_g1");
    step(1, 3'b010, 1, 3'b010, 2'b01, 1, 0, "t3_regrant_a");
    step(1, 3'b010, 1, 3'b010, 2'b01, 1, 0, "t3_regrant_b");
    step(1, 3'b000, 1, 3'b000, 2'b11, 0, 0, "t3_idle");

    // T4 watchdog: grant held 16 cycles, then forced release
    step(1, 3'b001, 0, 3'b001, 2'b00, 1, 0, "t4_g0");
    for (int i = 1; i < 16; i++)
      step(1, 3'b001, 0, 3'b001, 2'b00, 1, 0, "t4_hold");
    step(1, 3'b001, 0, 3'b000, 2'b11, 0, 1, "t4_timeout");
    step(1, 3'b011, 0, 3'b010, 2'b01, 1, 0, "t4_after_to_g1");

    // T5 abort: owner 1 drops request, then re-arbitration from IDLE
    step(1, 3'b001, 0, 3'b000, 2'b11, 0, 0, "t5_abort");
    step(1, 3'b001, 0, 3'b001, 2'b00, 1, 0, "t5_rearb_g0");
    // done on the timeout-limit edge: done wins, sole requester re-granted
    for (int i = 1; i < 16; i++)
      step(1, 3'b001, 0, 3'b001, 2'b00, 1, 0, "t5_hold");
    step(1, 3'b001, 1, 3'b001, 2'b00, 1, 0, "t5_done_at_limit");
    step(1, 3'b000, 1, 3'b000, 2'b11, 0, 0, "t5_idle");
    // done while idle does nothing
    step(1, 3'b000, 1, 3'b000, 2'b11, 0, 0, "t5_done_idle_a");
    step(1, 3'b000, 1, 3'b000, 2'b11, 0, 0, "t5_done_idle_b");

    // T6 reset mid-grant, then requester 0 first
    step(1, 3'b100, 0, 3'b100, 2'b10, 1, 0, "t6_g2");
    step(1, 3'b100, 0, 3'b100, 2'b10, 1, 0, "t6_g2_hold");
    step(0, 3'b100, 0, 3'b000, 2'b11, 0, 0, "t6_reset");
    step(1, 3'b111, 0, 3'b001, 2'b00, 1, 0, "t6_g0_first");
    step(1, 3'b000, 1, 3'b000, 2'b11, 0, 0, "t6_idle");

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      $display("FAIL drain: got %0d unchecked expectations, required 0", exp_q.size());
      n_bad += exp_q.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
